mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the CPU's instruction-fetch port and data port, and one unified synchronous word-wide SRAM. Accepts level-held requests from both ports, grants one per access with data priority, returns fetched or loaded words in held output registers, and pulses a per-port ready. Sits directly below the CPU, driving the CPU's `instr_out` and `data_out` inputs.

## Interface
- `MEM_AW`, 14: SRAM word-address width; byte addresses with any bit in [31:MEM_AW+2] set are out of range.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_read`  in  1  fetch request, level-held until `instr_ready`
- `instr_addr`  in  32  fetch byte address
- `instr_out`  out  32  fetched word, held until next fetch completes
- `instr_ready`  out  1  one-cycle pulse, fetch complete
- `data_read`  in  1  load request, level-held
- `data_write`  in  4  byte-lane store enables; any bit set = store request
- `data_addr`  in  32  load/store byte address
- `data_in`  in  32  store data, already lane-aligned
- `data_out`  out  32  loaded word, held until next load completes
- `data_ready`  out  1  one-cycle pulse, load/store complete
- `addr_err`  out  1  one-cycle pulse with the ready of an out-of-range access
- `mem_en`  out  1  SRAM access strobe
- `mem_we`  out  4  SRAM byte write enables
- `mem_addr`  out  MEM_AW  SRAM word address
- `mem_wdata`  out  32  SRAM write data
- `mem_rdata`  in  32  SRAM read data, valid the cycle after `mem_en`

## Operation
- States: IDLE, RESP. RESP remembers the granted port (INSTR/DATA), access kind (RD/WR) and out-of-range flag.
- IDLE: a port is eligible if its request is high AND its own ready is low this cycle (requester drops the request during its ready cycle; this also guarantees no back-to-back grants to one port while the other waits).
- Grant priority: eligible data port, else eligible instruction port, else stay IDLE.
- Data request with `data_write != 0` is a store even if `data_read` is also high.
- Grant cycle (IDLE, combinational): `mem_addr` = granted address bits [MEM_AW+1:2]; low two bits ignored; `mem_wdata` = `data_in`; `mem_we` = `data_write` for stores else 0; `mem_en` = 1 unless out of range. Next state RESP.
- RESP: `mem_en`=0, `mem_we`=0. At the closing edge: for reads, granted port's output register <= `mem_rdata` (0 if out of range); stores leave `data_out` unchanged; granted port's ready <= 1; `addr_err` <= out-of-range flag; state <= IDLE.
- Ungranted port's output register and ready are never disturbed.
- `mem_addr`/`mem_wdata` are don't-care when `mem_en`=0; drive 0.

## Timing
- Request seen in IDLE at cycle N -> SRAM strobe in N -> ready and output valid in N+2. Fixed latency 2 for reads, writes and out-of-range accesses.
- Peak throughput one access per 2 cycles; a new grant may occur in the same cycle another port's ready is high.
- Both ports requesting continuously: grants alternate D, I, D, I...
- Reset values: state IDLE, `instr_out`=0, `data_out`=0, `instr_ready`=0, `data_ready`=0, `addr_err`=0, `mem_en`=0, `mem_we`=0.
- Reset asserted during RESP: access abandoned, no ready pulse; a store whose strobe already occurred remains written in SRAM.
- Request changes during RESP are ignored; address/data are used only in the grant cycle.

## Structure
- Shared package: state enum (IDLE, RESP), port-select enum (PORT_INSTR, PORT_DATA), constant for word width 32.
- Single flat module; no sub-module warranted.

## Test plan
- Reset then fetch at 0x0000_0010 with SRAM word 4 = 0x0050_0093 -> `mem_en` with `mem_addr`=4 in grant cycle, `instr_out`=0x0050_0093 and one-cycle `instr_ready` two cycles later.
- Store `data_write`=4'b0100, `data_addr`=0x0000_0022, `data_in`=0x00AB_0000 -> `mem_we`=4'b0100, `mem_addr`=8; `data_ready` at +2; `data_out` unchanged.
- Fetch and load requested same cycle and held -> data granted first, fetch granted in data's ready cycle; grants alternate D, I, D, I thereafter.
- Load from 0x0001_0000 with MEM_AW=14 -> `mem_en` never asserts, `data_out`=0, `data_ready` and `addr_err` pulse together at +2.
- `data_read`=1 with `data_write`=4'b1111 -> treated as store, `mem_we`=4'b1111, `data_out` unchanged.
- Assert `rst` in RESP of a fetch -> no `instr_ready`, all outputs 0, next request served with normal latency 2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter_pkg : shared types for the instruction/data SRAM arbiter  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mem_arbiter_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter : data-priority arbiter of fetch and load/store ports     |
// | onto one synchronous word-wide SRAM, fixed two-cycle latency.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_AW = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_read,
   input  logic [WORD_W-1:0]   instr_addr,
   output logic [WORD_W-1:0]   instr_out,
   output logic                instr_ready,
   input  logic                data_read,
   input  logic [3:0]          data_write,
   input  logic [WORD_W-1:0]   data_addr,
   input  logic [WORD_W-1:0]   data_in,
   output logic [WORD_W-1:0]   data_out,
   output logic                data_ready,
   output logic                addr_err,
   output logic                mem_en,
   output logic [3:0]          mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [WORD_W-1:0]   mem_wdata,
   input  logic [WORD_W-1:0]   mem_rdata
);

   state_t              state_q, state_d;
   port_t               port_q, port_d;
   logic                wr_q, wr_d;
   logic                oor_q, oor_d;
   logic [WORD_W-1:0]   instr_out_q, instr_out_d;
   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                instr_ready_q, instr_ready_d;
   logic                data_ready_q, data_ready_d;
   logic                addr_err_q, addr_err_d;

   logic                w_data_elig;
   logic                w_instr_elig;
   logic [WORD_W-1:0]   w_sel_addr;
   logic                w_sel_oor;
   logic                w_unused_addr_bits;

   assign w_unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};

   // A port whose ready is high this cycle is dropping its request, so it is not eligible.
   assign w_data_elig  = (data_read || (data_write != 4'b0000)) && !data_ready_q;
   assign w_instr_elig = instr_read && !instr_ready_q;
   assign w_sel_addr   = w_data_elig ? data_addr : instr_addr;
   assign w_sel_oor    = |w_sel_addr[WORD_W-1:MEM_AW+2];

   always_comb begin
      state_d       = state_q;
      port_d        = port_q;
      wr_d          = wr_q;
      oor_d         = oor_q;
      instr_out_d   = instr_out_q;
      data_out_d    = data_out_q;
      instr_ready_d = 1'b0;
      data_ready_d  = 1'b0;
      addr_err_d    = 1'b0;
      mem_en        = 1'b0;
      mem_we        = 4'b0000;
      mem_addr      = '0;
      mem_wdata     = '0;

      case (state_q)
         ST_IDLE: begin
            // Gated by rst so the strobe stays low while reset is held.
            if (!rst && (w_data_elig || w_instr_elig)) begin
               state_d = ST_RESP;
               port_d  = w_data_elig ? PORT_DATA : PORT_INSTR;
               wr_d    = w_data_elig && (data_write != 4'b0000);
               oor_d   = w_sel_oor;
               if (!w_sel_oor) begin
                  mem_en    = 1'b1;
                  mem_addr  = w_sel_addr[MEM_AW+1:2];
                  mem_wdata = data_in;
                  mem_we    = wr_d ? data_write : 4'b0000;
               end
            end
         end
         ST_RESP: begin
            state_d    = ST_IDLE;
            addr_err_d = oor_q;
            if (port_q == PORT_DATA) begin
               data_ready_d = 1'b1;
               if (!wr_q) begin
                  data_out_d = oor_q ? '0 : mem_rdata;
               end
            end else begin
               instr_ready_d = 1'b1;
               instr_out_d   = oor_q ? '0 : mem_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         port_q        <= PORT_INSTR;
         wr_q          <= 1'b0;
         oor_q         <= 1'b0;
         instr_out_q   <= '0;
         data_out_q    <= '0;
         instr_ready_q <= 1'b0;
         data_ready_q  <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         port_q        <= port_d;
         wr_q          <= wr_d;
         oor_q         <= oor_d;
         instr_out_q   <= instr_out_d;
         data_out_q    <= data_out_d;
         instr_ready_q <= instr_ready_d;
         data_ready_q  <= data_ready_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign instr_out   = instr_out_q;
   assign instr_ready = instr_ready_q;
   assign data_out    = data_out_q;
   assign data_ready  = data_ready_q;
   assign addr_err    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int MEM_AW = 14;

   logic               clk;
   logic               rst;
   logic               instr_read;
   logic [31:0]        instr_addr;
   logic [31:0]        instr_out;
   logic               instr_ready;
   logic               data_read;
   logic [3:0]         data_write;
   logic [31:0]        data_addr;
   logic [31:0]        data_in;
   logic [31:0]        data_out;
   logic               data_ready;
   logic               addr_err;
   logic               mem_en;
   logic [3:0]         mem_we;
   logic [MEM_AW-1:0]  mem_addr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;

   logic [31:0]        sram [0:(1<<MEM_AW)-1];

   int checks;
   int failures;

   mem_arbiter #(.MEM_AW(MEM_AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_read  (instr_read),
      .instr_addr  (instr_addr),
      .instr_out   (instr_out),
      .instr_ready (instr_ready),
      .data_read   (data_read),
      .data_write  (data_write),
      .data_addr   (data_addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_ready  (data_ready),
      .addr_err    (addr_err),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= sram[mem_addr];
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < (1 << MEM_AW); i++) sram[i] = 32'h0;
      sram[4]  = 32'h0050_0093;
      sram[8]  = 32'h1122_3344;
      sram[12] = 32'hCAFE_F00D;
      sram[16] = 32'hDEAD_BEEF;
      sram[32] = 32'h1234_5678;
      mem_rdata  = 32'h0;
      rst        = 1'b1;
      instr_read = 1'b0;
      instr_addr = 32'h0;
      data_read  = 1'b0;
      data_write = 4'b0000;
      data_addr  = 32'h0;
      data_in    = 32'h0;
      tick();
      tick();
      chk("rst_instr_out", instr_out, 32'h0);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_readys", {29'h0, instr_ready, data_ready, addr_err}, 32'h0);
      chk("rst_mem_en", {27'h0, mem_en, mem_we}, 32'h0);
      rst = 1'b0;
      tick();

      // Fetch from 0x10
      instr_read = 1'b1;
      instr_addr = 32'h0000_0010;
      #1;
      chk("fetch_grant_en", {31'h0, mem_en}, 32'h1);
      chk("fetch_grant_addr", {18'h0, mem_addr}, 32'd4);
      chk("fetch_grant_we", {28'h0, mem_we}, 32'h0);
      tick();
      chk("fetch_resp_en", {31'h0, mem_en}, 32'h0);
      chk("fetch_resp_ready", {31'h0, instr_ready}, 32'h0);
      tick();
      chk("fetch_ready", {30'h0, instr_ready, data_ready}, 32'h2);
      chk("fetch_out", instr_out, 32'h0050_0093);
      chk("fetch_addr_err", {31'h0, addr_err}, 32'h0);
      instr_read = 1'b0;
      tick();
      chk("fetch_ready_pulse", {31'h0, instr_ready}, 32'h0);

      // Byte-lane store
      data_write = 4'b0100;
      data_addr  = 32'h0000_0022;
      data_in    = 32'h00AB_0000;
      #1;
      chk("store_en", {31'h0, mem_en}, 32'h1);
      chk("store_we", {28'h0, mem_we}, 32'h4);
      chk("store_addr", {18'h0, mem_addr}, 32'd8);
      chk("store_wdata", mem_wdata, 32'h00AB_0000);
      tick();
      chk("store_resp_ready", {31'h0, data_ready}, 32'h0);
      tick();
      chk("store_ready", {30'h0, instr_ready, data_ready}, 32'h1);
      chk("store_data_out", data_out, 32'h0);
      chk("store_sram", sram[8], 32'h11AB_3344);
      data_write = 4'b0000;
      tick();

      // Both ports request and hold: D, I, D, I
      data_read  = 1'b1;
      data_addr  = 32'h0000_0040;
      instr_read = 1'b1;
      instr_addr = 32'h0000_0080;
      #1;
      chk("arb_c0_grant", {13'h0, mem_en, mem_addr}, {13'h0, 1'b1, 14'd16});
      tick();
      chk("arb_c1_en", {31'h0, mem_en}, 32'h0);
      tick();
      chk("arb_c2_ready", {30'h0, instr_ready, data_ready}, 32'h1);
      chk("arb_c2_data_out", data_out, 32'hDEAD_BEEF);
      chk("arb_c2_grant", {13'h0, mem_en, mem_addr}, {13'h0, 1'b1, 14'd32});
      tick();
      chk("arb_c3_en", {31'h0, mem_en}, 32'h0);
      tick();
      chk("arb_c4_ready", {30'h0, instr_ready, data_ready}, 32'h2);
      chk("arb_c4_instr_out", instr_out, 32'h1234_5678);
      chk("arb_c4_grant", {13'h0, mem_en, mem_addr}, {13'h0, 1'b1, 14'd16});
      tick();
      tick();
      chk("arb_c6_ready", {30'h0, instr_ready, data_ready}, 32'h1);
      chk("arb_c6_grant", {13'h0, mem_en, mem_addr}, {13'h0, 1'b1, 14'd32});
      data_read = 1'b0;
      tick();
      tick();
      chk("arb_c8_ready", {30'h0, instr_ready, data_ready}, 32'h2);
      chk("arb_c8_idle", {31'h0, mem_en}, 32'h0);
      instr_read = 1'b0;
      tick();

      // Read and write together is a store
      data_read  = 1'b1;
      data_write = 4'b1111;
      data_addr  = 32'h0000_0030;
      data_in    = 32'h0BAD_CAFE;
      #1;
      chk("rw_we", {28'h0, mem_we}, 32'hF);
      chk("rw_addr", {18'h0, mem_addr}, 32'd12);
      tick();
      tick();
      chk("rw_ready", {31'h0, data_ready}, 32'h1);
      chk("rw_data_out", data_out, 32'hDEAD_BEEF);
      chk("rw_sram", sram[12], 32'h0BAD_CAFE);
      data_read  = 1'b0;
      data_write = 4'b0000;
      tick();

      // Out-of-range load
      data_read = 1'b1;
      data_addr = 32'h0001_0000;
      #1;
      chk("oor_grant_en", {31'h0, mem_en}, 32'h0);
      tick();
      chk("oor_resp_en", {31'h0, mem_en}, 32'h0);
      tick();
      chk("oor_ready_err", {30'h0, data_ready, addr_err}, 32'h3);
      chk("oor_data_out", data_out, 32'h0);
      data_read = 1'b0;
      tick();
      chk("oor_err_pulse", {31'h0, addr_err}, 32'h0);

      // Reset during fetch response
      instr_read = 1'b1;
      instr_addr = 32'h0000_0010;
      #1;
      chk("rstr_grant_en", {31'h0, mem_en}, 32'h1);
      tick();
      rst = 1'b1;
      #1;
      chk("rstr_instr_out", instr_out, 32'h0);
      chk("rstr_flags", {27'h0, instr_ready, data_ready, addr_err, mem_en, 1'b0}, 32'h0);
      tick();
      chk("rstr_no_ready", {31'h0, instr_ready}, 32'h0);
      chk("rstr_mem_en", {31'h0, mem_en}, 32'h0);
      rst = 1'b0;
      #1;
      chk("rstr_regrant", {13'h0, mem_en, mem_addr}, {13'h0, 1'b1, 14'd4});
      tick();
      chk("rstr_resp_ready", {31'h0, instr_ready}, 32'h0);
      tick();
      chk("rstr_ready", {31'h0, instr_ready}, 32'h1);
      chk("rstr_out", instr_out, 32'h0050_0093);
      instr_read = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
